// File: rtl/ysyx_25020047_sram.sv
// Word-organised SRAM slave with AXI4-Lite style channels.
// Independent read and write engines, each with a programmable
// response latency. Byte-lane writes; out-of-window accesses
// answer DECERR and never touch the array.
module ysyx_25020047_sram #(
    parameter logic [31:0] BASE       = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          RD_LAT     = 2,
    parameter int          WR_LAT     = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] araddr,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rvalid,
    input  logic        rready,

    input  logic [31:0] awaddr,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int          DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [32:0] SPAN        = 33'(DEPTH) << 2;
    localparam logic [3:0]  RD_CNT_INIT = (RD_LAT == 0) ? 4'd0 : 4'(RD_LAT - 1);
    localparam logic [3:0]  WR_CNT_INIT = (WR_LAT == 0) ? 4'd0 : 4'(WR_LAT - 1);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_e;

    // Window check uses modular subtraction so addresses below BASE wrap
    // to huge offsets and fall out of range.
    function automatic logic addr_in_range(input logic [31:0] addr);
        logic [31:0] offset;
        offset = addr - BASE;
        return {1'b0, offset} < SPAN;
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] addr_index(input logic [31:0] addr);
        logic [31:0] offset;
        offset = addr - BASE;
        return offset[DEPTH_LOG2+1:2];
    endfunction

    logic [31:0] mem [DEPTH];

    // Read engine state
    r_state_e    r_state_q;
    logic [3:0]  r_cnt_q;
    logic [31:0] ar_addr_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    // Write engine state
    w_state_e    w_state_q;
    logic [3:0]  w_cnt_q;
    logic        aw_done_q;
    logic        w_done_q;
    logic [31:0] aw_addr_q;
    logic [31:0] w_data_q;
    logic [3:0]  w_strb_q;
    logic [1:0]  bresp_q;

    // Combinational helpers
    logic        r_enter_resp;
    logic [31:0] r_addr_cur;
    logic        aw_hs;
    logic        w_hs;
    logic        aw_have;
    logic        w_have;
    logic [31:0] w_addr_cur;
    logic [31:0] w_data_cur;
    logic [3:0]  w_strb_cur;
    logic        w_enter_resp;
    logic        w_commit;

    // Decode which address feeds the read lookup and when the response is loaded.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        r_addr_cur   = ar_addr_q;
        r_enter_resp = 1'b0;
        if (r_state_q == R_IDLE) begin
            r_addr_cur   = araddr;
            r_enter_resp = arvalid && (RD_LAT == 0);
        end else if (r_state_q == R_WAIT) begin
            r_enter_resp = (r_cnt_q == 4'd0);
        end
    end

    // Read FSM: accept AR, count RD_LAT wait cycles, hold R until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= 4'd0;
            ar_addr_q <= 32'd0;
            rdata_q   <= 32'd0;
            rresp_q   <= RESP_OKAY;
        end else begin
            unique case (r_state_q)
                R_IDLE: begin
                    if (arvalid) begin
                        ar_addr_q <= araddr;
                        if (RD_LAT == 0) begin
                            r_state_q <= R_RESP;
                        end else begin
                            r_state_q <= R_WAIT;
                            r_cnt_q   <= RD_CNT_INIT;
                        end
                    end
                end
                R_WAIT: begin
                    if (r_cnt_q == 4'd0) begin
                        r_state_q <= R_RESP;
                    end else begin
                        r_cnt_q <= r_cnt_q - 4'd1;
                    end
                end
                R_RESP: begin
                    if (rready) begin
                        r_state_q <= R_IDLE;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
            // NOTE: non-blocking read samples the array before any same-edge write lands, giving pre-write data.
            if (r_enter_resp) begin
                if (addr_in_range(r_addr_cur)) begin
                    rdata_q <= mem[addr_index(r_addr_cur)];
                    rresp_q <= RESP_OKAY;
                end else begin
                    rdata_q <= 32'd0;
                    rresp_q <= RESP_DECERR;
                end
            end
        end
    end

    // Write-side handshakes, effective address/data, and the commit strobe.
    always_comb begin
        aw_hs        = (w_state_q == W_IDLE) && !aw_done_q && awvalid;
        w_hs         = (w_state_q == W_IDLE) && !w_done_q && wvalid;
        aw_have      = aw_done_q || aw_hs;
        w_have       = w_done_q || w_hs;
        w_addr_cur   = aw_done_q ? aw_addr_q : awaddr;
        w_data_cur   = w_done_q ? w_data_q : wdata;
        w_strb_cur   = w_done_q ? w_strb_q : wstrb;
        w_enter_resp = 1'b0;
        if (w_state_q == W_IDLE) begin
            w_enter_resp = aw_have && w_have && (WR_LAT == 0);
        end else if (w_state_q == W_WAIT) begin
            w_enter_resp = (w_cnt_q == 4'd0);
        end
        // A reset on the commit edge aborts the write.
        w_commit = !rst && w_enter_resp && addr_in_range(w_addr_cur);
    end

    // Write FSM: collect AW and W in any order, count WR_LAT, hold B until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_cnt_q   <= 4'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            aw_addr_q <= 32'd0;
            w_data_q  <= 32'd0;
            w_strb_q  <= 4'd0;
            bresp_q   <= RESP_OKAY;
        end else begin
            unique case (w_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        aw_addr_q <= awaddr;
                        aw_done_q <= 1'b1;
                    end
                    if (w_hs) begin
                        w_data_q <= wdata;
                        w_strb_q <= wstrb;
                        w_done_q <= 1'b1;
                    end
                    if (aw_have && w_have) begin
                        if (WR_LAT == 0) begin
                            w_state_q <= W_RESP;
                        end else begin
                            w_state_q <= W_WAIT;
                            w_cnt_q   <= WR_CNT_INIT;
                        end
                    end
                end
                W_WAIT: begin
                    if (w_cnt_q == 4'd0) begin
                        w_state_q <= W_RESP;
                    end else begin
                        w_cnt_q <= w_cnt_q - 4'd1;
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        w_state_q <= W_IDLE;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
            if (w_enter_resp) begin
                bresp_q <= addr_in_range(w_addr_cur) ? RESP_OKAY : RESP_DECERR;
            end
        end
    end

    // Byte-lane array write on the W_RESP entry edge.
    // NOTE: the array has no reset branch; contents survive rst and map onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb_cur[i]) begin
                    mem[addr_index(w_addr_cur)][8*i +: 8] <= w_data_cur[8*i +: 8];
                end
            end
        end
    end

    // Ready/valid decode from state, forced low while rst is high.
    assign arready = !rst && (r_state_q == R_IDLE);
    assign rvalid  = !rst && (r_state_q == R_RESP);
    assign awready = !rst && (w_state_q == W_IDLE) && !aw_done_q;
    assign wready  = !rst && (w_state_q == W_IDLE) && !w_done_q;
    assign bvalid  = !rst && (w_state_q == W_RESP);
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign bresp   = bresp_q;

endmodule

// File: tb/tb_ysyx_25020047_sram.sv
// Directed bench for ysyx_25020047_sram with default parameters
// (BASE 0x8000_0000, 1024 words, RD_LAT = WR_LAT = 2).
module tb_ysyx_25020047_sram;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int total  = 0;
    int passes = 0;

    ysyx_25020047_sram dut (
        .clk     (clk),
        .rst     (rst),
        .araddr  (araddr),
        .arvalid (arvalid),
        .arready (arready),
        .rdata   (rdata),
        .rresp   (rresp),
        .rvalid  (rvalid),
        .rready  (rready),
        .awaddr  (awaddr),
        .awvalid (awvalid),
        .awready (awready),
        .wdata   (wdata),
        .wstrb   (wstrb),
        .wvalid  (wvalid),
        .wready  (wready),
        .bresp   (bresp),
        .bvalid  (bvalid),
        .bready  (bready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full write with both channels presented together and bready held high.
    task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, output logic [1:0] resp, output int lat);
        int n;
        awaddr = a; awvalid = 1'b1;
        wdata  = d; wstrb   = s; wvalid = 1'b1;
        bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        n = 1;
        while (bvalid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
        lat  = n;
        resp = bresp;
        tick();
    endtask

    // Full read with rready held high.
    task automatic do_read(input string tag, input logic [31:0] a,
                           output logic [31:0] d, output logic [1:0] resp, output int lat);
        int n;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        tick();
        arvalid = 1'b0;
        n = 1;
        while (rvalid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
        lat  = n;
        d    = rdata;
        resp = rresp;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  resp;
        int          lat;
        int          n;

        rst = 1'b1;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_wready",  32'(wready),  32'd0);
        check("rst_rvalid",  32'(rvalid),  32'd0);
        check("rst_bvalid",  32'(bvalid),  32'd0);
        check("rst_rdata",   rdata,        32'd0);
        check("rst_rresp",   32'(rresp),   32'd0);
        check("rst_bresp",   32'(bresp),   32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_arready", 32'(arready), 32'd1);
        check("post_rst_awready", 32'(awready), 32'd1);
        check("post_rst_wready",  32'(wready),  32'd1);

        // Full-word write then read back, with latencies
        do_write("w1", 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, resp, lat);
        check("w1_bresp", 32'(resp), 32'd0);
        check("w1_lat",   32'(lat),  32'd3);
        check("w1_awready_next", 32'(awready), 32'd1);
        do_read("r1", 32'h8000_0010, d, resp, lat);
        check("r1_rdata", d,          32'hDEAD_BEEF);
        check("r1_rresp", 32'(resp),  32'd0);
        check("r1_lat",   32'(lat),   32'd3);
        check("r1_arready_next", 32'(arready), 32'd1);

        // Single-lane merge, and addr[1:0] ignored on read
        do_write("w2", 32'h8000_0010, 32'h00AB_0000, 4'b0100, resp, lat);
        check("w2_bresp", 32'(resp), 32'd0);
        do_read("r2", 32'h8000_0010, d, resp, lat);
        check("r2_rdata", d, 32'hDEAB_BEEF);
        do_read("r3", 32'h8000_0013, d, resp, lat);
        check("r3_rdata", d, 32'hDEAB_BEEF);

        // Empty strobe completes OKAY and changes nothing
        do_write("w3", 32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, resp, lat);
        check("w3_bresp", 32'(resp), 32'd0);
        do_read("r4", 32'h8000_0010, d, resp, lat);
        check("r4_rdata", d, 32'hDEAB_BEEF);

        // Window boundaries
        do_write("w4", 32'h8000_0000, 32'h1111_1111, 4'b1111, resp, lat);
        do_write("w5", 32'h8000_0FFC, 32'hCAFE_F00D, 4'b1111, resp, lat);
        check("w5_bresp", 32'(resp), 32'd0);
        do_read("r5", 32'h8000_0FFC, d, resp, lat);
        check("r5_rdata", d,         32'hCAFE_F00D);
        check("r5_rresp", 32'(resp), 32'd0);
        do_read("r6", 32'h7FFF_FFFC, d, resp, lat);
        check("r6_rdata", d,         32'd0);
        check("r6_rresp", 32'(resp), 32'd3);
        do_write("w6", 32'h8000_1000, 32'h1234_5678, 4'b1111, resp, lat);
        check("w6_bresp", 32'(resp), 32'd3);
        do_read("r7", 32'h8000_1000, d, resp, lat);
        check("r7_rdata", d,         32'd0);
        check("r7_rresp", 32'(resp), 32'd3);
        do_read("r8", 32'h8000_0000, d, resp, lat);
        check("r8_unchanged", d, 32'h1111_1111);
        do_read("r9", 32'h8000_0FFC, d, resp, lat);
        check("r9_unchanged", d, 32'hCAFE_F00D);

        // W two cycles ahead of AW, then B held off for five cycles
        bready = 1'b0;
        wdata = 32'h5566_7788; wstrb = 4'b1111; wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check("wfirst_wready",  32'(wready),  32'd0);
        check("wfirst_awready", 32'(awready), 32'd1);
        tick();
        check("wfirst_bvalid_early", 32'(bvalid), 32'd0);
        awaddr = 32'h8000_0020; awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        n = 1;
        while (bvalid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("wfirst_lat", 32'(n), 32'd3);
        awaddr = 32'h8000_0024; awvalid = 1'b1;
        wdata = 32'h9999_9999; wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bhold_bvalid",  32'(bvalid),  32'd1);
            check("bhold_bresp",   32'(bresp),   32'd0);
            check("bhold_awready", 32'(awready), 32'd0);
            check("bhold_wready",  32'(wready),  32'd0);
            tick();
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        tick();
        check("bhold_done_bvalid",  32'(bvalid),  32'd0);
        check("bhold_done_awready", 32'(awready), 32'd1);

        // R held off for five cycles, next AR waiting behind it
        rready = 1'b0;
        araddr = 32'h8000_0020; arvalid = 1'b1;
        tick();
        araddr = 32'h8000_0010;
        n = 1;
        while (rvalid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("rhold_lat", 32'(n), 32'd3);
        for (int i = 0; i < 5; i++) begin
            check("rhold_rvalid",  32'(rvalid),  32'd1);
            check("rhold_rdata",   rdata,        32'h5566_7788);
            check("rhold_rresp",   32'(rresp),   32'd0);
            check("rhold_arready", 32'(arready), 32'd0);
            tick();
        end
        rready = 1'b1;
        tick();
        check("rhold_done_rvalid",  32'(rvalid),  32'd0);
        check("rhold_done_arready", 32'(arready), 32'd1);
        tick();
        arvalid = 1'b0;
        n = 1;
        while (rvalid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("b2b_lat",   32'(n), 32'd3);
        check("b2b_rdata", rdata,  32'hDEAB_BEEF);
        tick();

        // Read and write of the same word entering their response states together
        do_write("w7", 32'h8000_0030, 32'hAAAA_0001, 4'b1111, resp, lat);
        araddr = 32'h8000_0030; arvalid = 1'b1; rready = 1'b1;
        awaddr = 32'h8000_0030; awvalid = 1'b1;
        wdata = 32'hBBBB_0002; wstrb = 4'b1111; wvalid = 1'b1; bready = 1'b1;
        tick();
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        tick(); tick();
        check("align_rvalid", 32'(rvalid), 32'd1);
        check("align_bvalid", 32'(bvalid), 32'd1);
        check("align_rdata",  rdata,       32'hAAAA_0001);
        check("align_bresp",  32'(bresp),  32'd0);
        tick();
        do_read("r10", 32'h8000_0030, d, resp, lat);
        check("align_new", d, 32'hBBBB_0002);

        // Reset pulse on the last W_WAIT cycle aborts the write
        awaddr = 32'h8000_0030; awvalid = 1'b1;
        wdata = 32'hCCCC_0003; wstrb = 4'b1111; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        tick();
        check("abort_bvalid_wait", 32'(bvalid), 32'd0);
        rst = 1'b1;
        tick();
        check("abort_rst_awready", 32'(awready), 32'd0);
        rst = 1'b0;
        #1;
        check("abort_awready", 32'(awready), 32'd1);
        check("abort_wready",  32'(wready),  32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_bvalid", 32'(bvalid), 32'd0);
        end
        do_read("r11", 32'h8000_0030, d, resp, lat);
        check("abort_unchanged", d, 32'hBBBB_0002);
        do_read("r12", 32'h8000_0010, d, resp, lat);
        check("rst_keeps_mem", d, 32'hDEAB_BEEF);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/ysyx_25020047_sram.md
YSYX_25020047_SRAM -- requirements
Module: ysyx_25020047_SRAM

Interface
REQ-001 SHALL have parameter BASE, default 32'h8000_0000, byte address of word 0.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10, giving 2^DEPTH_LOG2 32-bit words.
REQ-003 SHALL have parameter RD_LAT, default 2, giving extra wait cycles between AR handshake and rvalid (range 0..15).
REQ-004 SHALL have parameter WR_LAT, default 2, giving extra wait cycles between write commit-ready and bvalid (range 0..15).
REQ-005 SHALL have ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- araddr  in  32  read byte address
- arvalid  in  1  / arready  out  1  read-address handshake
- rdata  out  32  read word
- rresp  out  2  00 OKAY, 11 DECERR
- rvalid  out  1  / rready  in  1  read-data handshake
- awaddr  in  32  write byte address
- awvalid  in  1  / awready  out  1  write-address handshake
- wdata  in  32  write word, already lane-shifted by the initiator
- wstrb  in  4  byte-lane enables
- wvalid  in  1  / wready  out  1  write-data handshake
- bresp  out  2  00 OKAY, 11 DECERR
- bvalid  out  1  / bready  in  1  write-response handshake
REQ-006 Clock port clk and reset port rst SHALL be the only clock and reset; reset is synchronous and active-high.

Function
REQ-007 Handshake on any channel SHALL occur on a rising edge where valid and ready are both 1.
REQ-008 Address decode: offset = addr - BASE; in range iff offset < 4*2^DEPTH_LOG2; word index = offset[DEPTH_LOG2+1:2]; addr[1:0] ignored.
REQ-009 Read FSM states: R_IDLE, R_WAIT, R_RESP.
REQ-010 R_IDLE: arready=1; on AR handshake, latch araddr; go to R_WAIT with counter=RD_LAT-1, or directly to R_RESP if RD_LAT=0.
REQ-011 R_WAIT: arready=0; decrement the counter each cycle; at counter 0, go to R_RESP.
REQ-012 On the edge entering R_RESP: rdata = mem[index] and rresp=00 if in range, otherwise rdata=0 and rresp=11.
REQ-013 R_RESP: rvalid=1; rdata and rresp SHALL be held stable until the R handshake, then return to R_IDLE (rvalid=0 next cycle).
REQ-014 Write FSM states: W_IDLE, W_WAIT, W_RESP.
REQ-015 W_IDLE address/data acceptance:
- awready=1 until the address is latched; wready=1 until the data/strobe are latched.
- AW and W may arrive in the same cycle or in either order.
- Once both are latched, go to W_WAIT with counter=WR_LAT-1, or directly to W_RESP if WR_LAT=0.
REQ-016 W_WAIT: awready=wready=0; decrement the counter; at counter 0, go to W_RESP.
REQ-017 On the edge entering W_RESP: if in range, write each byte lane i where wstrb[i]=1 and bresp=00; if out of range, leave memory untouched and bresp=11.
REQ-018 W_RESP: bvalid=1, bresp held until the B handshake, then return to W_IDLE.
REQ-019 wstrb=0000 SHALL complete normally with bresp=00 and no memory change.
REQ-020 Read and write FSMs SHALL run independently and concurrently.
REQ-021 If the R_RESP entry edge and the W_RESP entry edge coincide on the same word, rdata SHALL return the pre-write value.
REQ-022 A handshake while rready/bready is held 1 SHALL complete in the same cycle valid rises; back-to-back transactions SHALL accept the next AR/AW one cycle after R/B completion.

Reset
REQ-023 While rst=1, outputs SHALL be: arready=awready=wready=0, rvalid=bvalid=0, rdata=0, rresp=bresp=00; both FSMs in IDLE with address/data latches cleared.
REQ-024 Reset asserted mid-transaction SHALL abort that transaction with no response; a write not yet at W_RESP entry SHALL NOT modify memory.
REQ-025 Memory contents SHALL NOT be cleared by reset.
REQ-026 From the first cycle after rst deasserts, arready=awready=wready=1.

Verification
REQ-027 Write awaddr=0x8000_0010, wdata=0xDEADBEEF, wstrb=1111, bready=1 -> bvalid 3 cycles after the last AW/W handshake (WR_LAT=2), bresp=00; a subsequent read of 0x8000_0010 -> rdata=0xDEADBEEF, rvalid RD_LAT+1 cycles after AR.
REQ-028 Write 0x8000_0010 with wdata=0x00AB0000, wstrb=0100 over 0xDEADBEEF -> read returns 0xDEABBEEF; read via araddr=0x8000_0013 returns the same word.
REQ-029 Read araddr=0x7FFF_FFFC and write awaddr=0x8000_1000 (DEPTH_LOG2=10) -> rresp=11 with rdata=0; bresp=11; memory unchanged.
REQ-030 W presented 2 cycles before AW, with rready/bready held 0 for 5 cycles -> bvalid/rvalid stay 1 with rdata/bresp stable, and no new AR/AW is accepted until the handshake.
REQ-031 Read and write to the same word with entry edges aligned -> rdata is the old value, and the next read returns the new value.
REQ-032 rst pulsed for 1 cycle during W_WAIT -> no bvalid, target word unchanged, awready=1 on the cycle after reset.
